// File: rtl/gf_exp_seq.sv
// gf_exp_seq
//   Computes r = base^e mod P(x) over GF(2^m) using left-to-right
//   square-and-multiply. An external combinational carry-less
//   multiply/reduce unit is driven through the dp_* ports, and one product
//   is consumed per cycle.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | waiting for a command, cmd_ready=1
//   SQR   | acc <= acc*acc mod P, then branch on exponent bit idx
//   MUL   | acc <= acc*base mod P, then move to the next lower exponent bit
//   DONE  | result presented until res_ready, cmd_ready=0
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   cmd_valid/cmd_ready  command handshake
//   cmd_base/exp/grade/polyn  operands, field degree m, reduction polynomial
//   res_valid/res_ready  result handshake
//   res_data, res_err    result element, illegal-grade flag
//   dp_a, dp_b, dp_req   multiplier operands, capture strobe
//   dp_grade, dp_polyn   latched field parameters for the datapath
//   dp_result            reduced product from the datapath, same cycle
module gf_exp_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int EXP_WIDTH  = 32,
    localparam int GW = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [DATA_WIDTH-1:0] cmd_base,
    input  logic [EXP_WIDTH-1:0]  cmd_exp,
    input  logic [GW-1:0]         cmd_grade,
    input  logic [DATA_WIDTH:0]   cmd_polyn,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  res_err,
    output logic [DATA_WIDTH-1:0] dp_a,
    output logic [DATA_WIDTH-1:0] dp_b,
    output logic [GW-1:0]         dp_grade,
    output logic [DATA_WIDTH:0]   dp_polyn,
    output logic                  dp_req,
    input  logic [DATA_WIDTH-1:0] dp_result
);

    localparam int IW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;
    localparam logic [IW-1:0] IDX_MAX = IW'(EXP_WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQR  = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] base_q, base_d;
    logic [EXP_WIDTH-1:0]  exp_q, exp_d;
    logic [GW-1:0]         grade_q, grade_d;
    logic [DATA_WIDTH:0]   polyn_q, polyn_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic                  err_q, err_d;
    logic                  grade_bad;

    assign grade_bad = (cmd_grade == '0) || (cmd_grade > GW'(DATA_WIDTH));
    assign dp_grade  = grade_q;
    assign dp_polyn  = polyn_q;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        base_d    = base_q;
        exp_d     = exp_q;
        grade_d   = grade_q;
        polyn_d   = polyn_q;
        idx_d     = idx_q;
        err_d     = err_q;
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        res_data  = '0;
        res_err   = 1'b0;
        dp_a      = '0;
        dp_b      = '0;
        dp_req    = 1'b0;

        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    base_d  = cmd_base;
                    exp_d   = cmd_exp;
                    grade_d = cmd_grade;
                    polyn_d = cmd_polyn;
                    acc_d   = DATA_WIDTH'(1);
                    idx_d   = IDX_MAX;
                    err_d   = grade_bad;
                    state_d = grade_bad ? DONE : SQR;
                end
            end
            SQR: begin
                dp_a   = acc_q;
                dp_b   = acc_q;
                dp_req = 1'b1;
                acc_d  = dp_result;
                // The bit index only moves after the optional multiply, so
                // MUL is the one that decrements when the bit is set.
                if (exp_q[idx_q]) begin
                    state_d = MUL;
                end else if (idx_q == '0) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            MUL: begin
                dp_a   = acc_q;
                dp_b   = base_q;
                dp_req = 1'b1;
                acc_d  = dp_result;
                if (idx_q == '0) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q - IW'(1);
                    state_d = SQR;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                res_err   = err_q;
                // acc was preset to 1 on accept; an illegal grade reports 0.
                res_data  = err_q ? '0 : acc_q;
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            base_q  <= '0;
            exp_q   <= '0;
            grade_q <= '0;
            polyn_q <= '0;
            idx_q   <= IDX_MAX;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            base_q  <= base_d;
            exp_q   <= exp_d;
            grade_q <= grade_d;
            polyn_q <= polyn_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

endmodule
